// File: rtl/pwm_channel_scheduler.sv
// Four-channel PWM scheduler: shared period/high counters, boundary-aligned
// value transfer, arm sequencing and command-timeout failsafe.
module pwm_channel_scheduler #(
  parameter int INPUT_BIT_WIDTH = 10,
  parameter int MIN_HIGH_US     = 1000,
  parameter int MAX_HIGH_US     = 2000,
  parameter int PERIOD_US       = 2500,
  parameter int ARM_PERIODS     = 200,
  parameter int TIMEOUT_PERIODS = 20
) (
  input  logic                         us_clk,
  input  logic                         resetn,
  input  logic [4*INPUT_BIT_WIDTH-1:0] motor_val_in,
  input  logic                         update_valid,
  input  logic                         arm_req,
  output logic [15:0]                  period_counter,
  output logic [INPUT_BIT_WIDTH-1:0]   high_counter,
  output logic [4*INPUT_BIT_WIDTH-1:0] motor_val_out,
  output logic                         period_start,
  output logic                         armed,
  output logic                         failsafe
);

  localparam int W = INPUT_BIT_WIDTH;
  localparam logic [15:0] LAST = 16'(PERIOD_US - 1);
  localparam logic [15:0] MIN_H = 16'(MIN_HIGH_US);
  localparam logic [W-1:0] CLAMP = W'(MAX_HIGH_US - MIN_HIGH_US);
  localparam logic [W-1:0] HMAX = '1;
  localparam logic [15:0] ARM_LAST = 16'(ARM_PERIODS - 1);
  localparam logic [15:0] TMO_LIM = 16'(TIMEOUT_PERIODS);

  typedef enum logic [1:0] {
    DISARMED,
    ARMING,
    ARMED,
    FAILSAFE
  } state_e;

  state_e state_q, state_d;
  logic [15:0] period_counter_q, period_counter_d;
  logic [W-1:0] high_counter_q, high_counter_d;
  logic [4*W-1:0] motor_val_out_q, motor_val_out_d;
  logic [4*W-1:0] pending_q, pending_d;
  logic period_start_q, period_start_d;
  logic [15:0] arm_cnt_q, arm_cnt_d;
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic upd_seen_q, upd_seen_d;
  logic run_q, run_d;
  logic boundary;
  logic seen_now;
  logic [W-1:0] ch_in;

  always_comb begin
    state_d = state_q;
    period_counter_d = period_counter_q;
    high_counter_d = high_counter_q;
    motor_val_out_d = motor_val_out_q;
    pending_d = pending_q;
    arm_cnt_d = arm_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    upd_seen_d = upd_seen_q | update_valid;
    seen_now = upd_seen_q | update_valid;
    run_d = 1'b1;
    ch_in = '0;
    boundary = (period_counter_q == LAST);

    // first cycle after reset release holds 0 so period_start pulses at once
    if (!run_q || boundary) begin
      period_counter_d = '0;
    end else begin
      period_counter_d = period_counter_q + 16'd1;
    end
    period_start_d = (period_counter_d == 16'd0);

    if (period_counter_d <= MIN_H) begin
      high_counter_d = '0;
    end else if (high_counter_q != HMAX) begin
      high_counter_d = high_counter_q + 1'b1;
    end

    if (update_valid) begin
      for (int i = 0; i < 4; i++) begin
        ch_in = motor_val_in[i*W +: W];
        pending_d[i*W +: W] = (ch_in > CLAMP) ? CLAMP : ch_in;
      end
    end

    if (boundary) begin
      upd_seen_d = 1'b0;
      unique case (state_q)
        DISARMED: begin
          if (arm_req) begin
            state_d = ARMING;
            arm_cnt_d = '0;
          end
        end
        ARMING: begin
          if (!arm_req) begin
            state_d = DISARMED;
          end else if (arm_cnt_q == ARM_LAST) begin
            state_d = ARMED;
            tmo_cnt_d = '0;
            pending_d = '0;
          end else begin
            arm_cnt_d = arm_cnt_q + 16'd1;
          end
        end
        ARMED: begin
          if (!arm_req) begin
            state_d = DISARMED;
          end else if (seen_now) begin
            tmo_cnt_d = '0;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
            if (tmo_cnt_d == TMO_LIM) state_d = FAILSAFE;
          end
        end
        FAILSAFE: begin
          if (!arm_req) state_d = DISARMED;
        end
        default: state_d = DISARMED;
      endcase
      motor_val_out_d = (state_d == ARMED) ? pending_d : '0;
    end
  end

  always_ff @(posedge us_clk) begin
    if (!resetn) begin
      state_q <= DISARMED;
      period_counter_q <= '0;
      high_counter_q <= '0;
      motor_val_out_q <= '0;
      pending_q <= '0;
      period_start_q <= 1'b0;
      arm_cnt_q <= '0;
      tmo_cnt_q <= '0;
      upd_seen_q <= 1'b0;
      run_q <= 1'b0;
    end else begin
      state_q <= state_d;
      period_counter_q <= period_counter_d;
      high_counter_q <= high_counter_d;
      motor_val_out_q <= motor_val_out_d;
      pending_q <= pending_d;
      period_start_q <= period_start_d;
      arm_cnt_q <= arm_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      upd_seen_q <= upd_seen_d;
      run_q <= run_d;
    end
  end

  assign period_counter = period_counter_q;
  assign high_counter = high_counter_q;
  assign motor_val_out = motor_val_out_q;
  assign period_start = period_start_q;
  assign armed = (state_q == ARMED);
  assign failsafe = (state_q == FAILSAFE);

endmodule

// File: tb/tb_pwm_channel_scheduler.sv
// Scoreboard bench: per-period expectations queued at stimulus time,
// checked at each period start and again on the boundary cycle.
module tb_pwm_channel_scheduler;

  localparam int W = 10;
  localparam int P = 2500;

  logic us_clk = 1'b0;
  logic resetn;
  logic [4*W-1:0] motor_val_in;
  logic update_valid;
  logic arm_req;
  logic [15:0] period_counter;
  logic [W-1:0] high_counter;
  logic [4*W-1:0] motor_val_out;
  logic period_start;
  logic armed;
  logic failsafe;

  pwm_channel_scheduler #(
    .INPUT_BIT_WIDTH(W),
    .MIN_HIGH_US(1000),
    .MAX_HIGH_US(2000),
    .PERIOD_US(P),
    .ARM_PERIODS(2),
    .TIMEOUT_PERIODS(3)
  ) dut (
    .us_clk(us_clk),
    .resetn(resetn),
    .motor_val_in(motor_val_in),
    .update_valid(update_valid),
    .arm_req(arm_req),
    .period_counter(period_counter),
    .high_counter(high_counter),
    .motor_val_out(motor_val_out),
    .period_start(period_start),
    .armed(armed),
    .failsafe(failsafe)
  );

  always #5 us_clk = ~us_clk;

  typedef struct {
    logic armed;
    logic fs;
    logic [4*W-1:0] vals;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  logic cur_valid = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last = 0;
  logic have_last = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [4*W-1:0] rep4(input int v);
    return {W'(v), W'(v), W'(v), W'(v)};
  endfunction

  task automatic push(input logic a, input logic f, input logic [4*W-1:0] v);
    exp_t e;
    e.armed = a;
    e.fs = f;
    e.vals = v;
    exp_q.push_back(e);
  endtask

  task automatic wait_ps();
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < P + 10 && !hit; i++) begin
      @(negedge us_clk);
      if (period_start) hit = 1'b1;
    end
    if (!hit) chk("wait_ps_timeout", 64'(hit), 64'd1);
  endtask

  task automatic wait_cnt(input int n);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < P + 10 && !hit; i++) begin
      @(negedge us_clk);
      if (int'(period_counter) == n) hit = 1'b1;
    end
    if (!hit) chk("wait_cnt_timeout", 64'(hit), 64'd1);
  endtask

  // Called at the negedge of a period-start cycle; returns at the next one.
  task automatic run_period(input logic arm, input int arm_at,
                            input logic upd, input int upd_at,
                            input logic [4*W-1:0] v,
                            input logic ea, input logic ef,
                            input logic [4*W-1:0] ev);
    int c;
    push(ea, ef, ev);
    for (int i = 0; i < P; i++) begin
      c = int'(period_counter);
      if (c == arm_at) arm_req = arm;
      update_valid = upd && (c == upd_at);
      motor_val_in = v;
      @(negedge us_clk);
    end
    update_valid = 1'b0;
  endtask

  always @(posedge us_clk) begin
    if (!resetn) begin
      cur_valid = 1'b0;
      have_last = 1'b0;
    end
  end

  always @(negedge us_clk) begin
    cyc++;
    if (resetn) begin
      if (period_start) begin
        if (have_last) chk("period_len", 64'(cyc - last), 64'(P));
        last = cyc;
        have_last = 1'b1;
        chk("ps_cnt", 64'(period_counter), 64'd0);
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          cur_valid = 1'b1;
          chk("armed", 64'(armed), 64'(cur.armed));
          chk("failsafe", 64'(failsafe), 64'(cur.fs));
          chk("vals", 64'(motor_val_out), 64'(cur.vals));
        end
      end
      if (period_counter == 16'd1) chk("ps_low", 64'(period_start), 64'd0);
      if (period_counter == 16'd1000) chk("high_1000", 64'(high_counter), 64'd0);
      if (period_counter == 16'd1005) chk("high_1005", 64'(high_counter), 64'd5);
      if (period_counter == 16'(P - 1)) begin
        chk("high_sat", 64'(high_counter), 64'd1023);
        if (cur_valid) begin
          chk("hold_vals", 64'(motor_val_out), 64'(cur.vals));
          chk("hold_armed", 64'(armed), 64'(cur.armed));
          cur_valid = 1'b0;
        end
      end
    end
  end

  logic [4*W-1:0] v900;

  initial begin
    resetn = 1'b0;
    arm_req = 1'b0;
    update_valid = 1'b0;
    motor_val_in = '0;
    v900 = {W'(500), W'(900), W'(500), W'(500)};
    repeat (3) @(negedge us_clk);
    chk("rst_cnt", 64'(period_counter), 64'd0);
    chk("rst_high", 64'(high_counter), 64'd0);
    chk("rst_vals", 64'(motor_val_out), 64'd0);
    chk("rst_ps", 64'(period_start), 64'd0);
    chk("rst_armed", 64'(armed), 64'd0);
    chk("rst_fs", 64'(failsafe), 64'd0);

    push(1'b0, 1'b0, '0);
    resetn = 1'b1;
    wait_ps();

    repeat (3) run_period(0, 0, 0, 0, '0, 0, 0, '0);

    run_period(1, 0, 1, 100, rep4(500), 0, 0, '0);
    run_period(1, 0, 1, 100, rep4(500), 0, 0, '0);
    run_period(1, 0, 1, 100, rep4(500), 1, 0, '0);
    run_period(1, 0, 1, 100, rep4(500), 1, 0, rep4(500));

    run_period(1, 0, 1, 1200, v900, 1, 0, v900);
    run_period(1, 0, 1, 200, rep4(1023), 1, 0, rep4(1000));
    run_period(1, 0, 1, P - 1, rep4(700), 1, 0, rep4(700));
    run_period(0, 1300, 1, 100, rep4(700), 0, 0, '0);

    run_period(1, 0, 0, 0, '0, 0, 0, '0);
    run_period(1, 0, 0, 0, '0, 0, 0, '0);
    run_period(1, 0, 0, 0, '0, 1, 0, '0);
    run_period(1, 0, 1, 100, rep4(400), 1, 0, rep4(400));
    run_period(1, 0, 0, 0, '0, 1, 0, rep4(400));
    run_period(1, 0, 0, 0, '0, 1, 0, rep4(400));
    run_period(1, 0, 0, 0, '0, 0, 1, '0);
    run_period(1, 0, 1, 100, rep4(600), 0, 1, '0);
    run_period(0, 0, 0, 0, '0, 0, 0, '0);

    run_period(1, 0, 0, 0, '0, 0, 0, '0);
    run_period(1, 0, 0, 0, '0, 0, 0, '0);
    run_period(1, 0, 0, 0, '0, 1, 0, '0);
    run_period(1, 0, 1, 100, rep4(800), 1, 0, rep4(800));

    wait_cnt(1800);
    chk("pre_rst_vals", 64'(motor_val_out), 64'(rep4(800)));
    resetn = 1'b0;
    @(negedge us_clk);
    chk("mid_rst_cnt", 64'(period_counter), 64'd0);
    chk("mid_rst_vals", 64'(motor_val_out), 64'd0);
    chk("mid_rst_armed", 64'(armed), 64'd0);
    chk("mid_rst_fs", 64'(failsafe), 64'd0);
    chk("mid_rst_high", 64'(high_counter), 64'd0);
    arm_req = 1'b0;
    push(1'b0, 1'b0, '0);
    resetn = 1'b1;
    wait_ps();
    wait_cnt(P - 1);
    @(negedge us_clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
